fifo_double_line_buffer: RTL and testbench
==========================================

Name: fifo_double_line_buffer

Overview:
Two-line pixel buffer that feeds a 3x3 edge-detection window.
- Accepts one 8-bit raster-scan pixel per write-enabled clock.
- Presents a vertical 3-pixel column: the current pixel plus the pixels exactly one and two image lines above it.
- Sits between the pixel source and the 3x3 window/convolution stage.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- LINE_WIDTH, 5, pixels per image line, which is the depth of each line FIFO; any value >= 2 is legal.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- we_i  input  1  write enable; one pixel accepted per clock while high.
- data_i  input  DATA_WIDTH  incoming pixel.
- data0_o  output  DATA_WIDTH  registered copy of the most recently accepted pixel (current line).
- data1_o  output  DATA_WIDTH  pixel accepted LINE_WIDTH writes earlier (line above).
- data2_o  output  DATA_WIDTH  pixel accepted 2*LINE_WIDTH writes earlier (two lines above).
- done_o  output  1  column-valid strobe.

Behaviour:
- Reset (asynchronous, rst=1):
  - data0_o, data1_o, data2_o and done_o all go to 0.
  - The write counter and both FIFO pointers clear.
  - Line memory contents need not be cleared; outputs are gated by the counter.
  - Reset asserted mid-stream discards all buffered pixels; the next write is treated as pixel 0.
- Structure:
  - Two cascaded LINE_WIDTH-deep FIFOs, line1 followed by line2.
  - Each FIFO is a circular RAM with a shared wrap-around index 0..LINE_WIDTH-1.
  - A write reads the old slot and overwrites it in the same cycle.
- On a clock edge with we_i=1 (pixel k, counting from 0 after reset), in parallel:
  - data0_o <= data_i.
  - data1_o <= line1 oldest entry, i.e. pixel k-LINE_WIDTH; 0 if k < LINE_WIDTH.
  - data2_o <= line2 oldest entry, i.e. pixel k-2*LINE_WIDTH; 0 if k < 2*LINE_WIDTH.
  - line1 stores data_i; its displaced entry moves into line2; line2's displaced entry is dropped.
  - The index wraps from LINE_WIDTH-1 to 0.
  - Counter increments, saturating at 2*LINE_WIDTH.
- Latency: 1 clock from write to updated outputs. There is no back-pressure; every we_i=1 cycle is accepted.
- done_o:
  - Registered. It is 1 in the cycle after a write where k >= 2*LINE_WIDTH, meaning all three column outputs hold real pixels.
  - It is 0 after any cycle with we_i=0 or with k < 2*LINE_WIDTH.
- we_i=0: data0_o, data1_o, data2_o, memories, index and counter hold their values; done_o goes to 0.
- Gaps in we_i do not break line alignment, because alignment is by write count, not by clock.
- Counter saturation: after 2*LINE_WIDTH writes the buffer streams indefinitely. The index continues to wrap and no overflow condition exists.
- data_i is ignored when we_i=0.

Test Plan:
- Reset check: assert rst for 1 cycle -> all outputs 0; releasing reset with we_i=0 keeps all outputs 0.
- Fill and stream, LINE_WIDTH=5: write data_i = 0..14 on 15 consecutive cycles -> after write k, data0_o=k.
  - data1_o = k-5 for k>=5, else 0.
  - data2_o = k-10 for k>=10, else 0.
  - done_o=1 only after k=10..14, where the columns are (10,5,0) through (14,9,4).
- Stall: same stream with we_i low for 3 cycles between pixel 7 and pixel 8 -> outputs hold (7,2,0) during the gap with done_o=0; pixel 8 then yields (8,3,0); alignment is unchanged.
- Wrap/long run: write 0..29 -> after k=29 outputs are (29,24,19) with done_o=1; columns stay correct across many index wraps.
- Reset mid-stream: write 0..12, pulse rst, then write 100..114 -> outputs restart at (100,0,0); the first done_o follows pixel 110, giving column (110,105,100); no pre-reset data ever appears.
- Parameter sweep: LINE_WIDTH=2 and LINE_WIDTH=8 repeat the fill-and-stream check with thresholds scaled to LINE_WIDTH and 2*LINE_WIDTH.

Source files
------------

// File: rtl/fifo_double_line_buffer.sv
// Two-line pixel buffer feeding a 3x3 window stage.
// Each accepted pixel produces a vertical column: the pixel itself plus the
// pixels one and two image lines above it. Two cascaded circular line RAMs
// share one wrap-around index. A saturating write counter gates the column
// outputs until the lines behind the current pixel hold real data.
module fifo_double_line_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int LINE_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic [DATA_WIDTH-1:0] data0_o,
   output logic [DATA_WIDTH-1:0] data1_o,
   output logic [DATA_WIDTH-1:0] data2_o,
   output logic                  done_o
);

   localparam int IDX_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam int CNT_W = $clog2(2 * LINE_WIDTH + 1);

   localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(LINE_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE_LINE  = CNT_W'(LINE_WIDTH);
   localparam logic [CNT_W-1:0] CNT_TWO_LINES = CNT_W'(2 * LINE_WIDTH);

   logic [DATA_WIDTH-1:0] line1_mem [LINE_WIDTH];
   logic [DATA_WIDTH-1:0] line2_mem [LINE_WIDTH];

   logic [IDX_W-1:0]      idx;
   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] line1_old;
   logic [DATA_WIDTH-1:0] line2_old;
   logic                  line1_full;
   logic                  line2_full;

   // Oldest entry of each line sits in the slot about to be overwritten.
   assign line1_old  = line1_mem[idx];
   assign line2_old  = line2_mem[idx];
   // Line contents count as real pixels only once enough writes have passed.
   assign line1_full = (cnt >= CNT_ONE_LINE);
   assign line2_full = (cnt >= CNT_TWO_LINES);

   // Column outputs, done strobe, shared index and saturating write counter.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, letting the read-then-overwrite of a slot and
   // the index advance all happen in the same cycle without ordering hazards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data0_o <= '0;
         data1_o <= '0;
         data2_o <= '0;
         done_o  <= 1'b0;
         idx     <= '0;
         cnt     <= '0;
      end else if (we_i) begin
         data0_o <= data_i;
         data1_o <= line1_full ? line1_old : '0;
         data2_o <= line2_full ? line2_old : '0;
         done_o  <= line2_full;
         idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         if (!line2_full) begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         done_o <= 1'b0;
      end
   end

   // Line RAM update: line1 takes the new pixel, its displaced entry moves
   // into line2, and line2's displaced entry falls off the end.
   // NOTE: the line RAMs are deliberately left out of reset; stale contents
   // never reach the outputs because the write counter gates them, and an
   // unreset array maps onto plain RAM instead of a bank of reset flops.
   always_ff @(posedge clk) begin
      if (we_i) begin
         line1_mem[idx] <= data_i;
         line2_mem[idx] <= line1_old;
      end
   end

endmodule

// File: tb/tb_fifo_double_line_buffer.sv
// Self-checking bench for fifo_double_line_buffer.
// Three instances (LINE_WIDTH 5, 2, 8) share one stimulus stream. A
// reference model built from the history of written pixels fills a
// scoreboard queue at drive time; entries are popped and compared one clock
// later. A hand-written table covers the stall case for LINE_WIDTH=5, and a
// few explicit checks cover reset and the named columns.
module tb_fifo_double_line_buffer;

   typedef struct packed {
      logic       done;
      logic [7:0] d2;
      logic [7:0] d1;
      logic [7:0] d0;
   } col_t;

   typedef struct packed {
      col_t c5;
      col_t c2;
      col_t c8;
   } sb_t;

   typedef struct {
      logic       we;
      logic [7:0] data;
      col_t       exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       we_i = 1'b0;
   logic [7:0] data_i = '0;

   logic [7:0] d0_5, d1_5, d2_5, d0_2, d1_2, d2_2, d0_8, d1_8, d2_8;
   logic       done_5, done_2, done_8;

   int n_vec = 0;
   int n_err = 0;

   int   hist[$];
   sb_t  sb_q[$];
   col_t last5, last2, last8;
   vec_t tab[16];

   always #5 clk = ~clk;

   fifo_double_line_buffer #(.DATA_WIDTH(8), .LINE_WIDTH(5)) dut5 (
      .clk(clk), .rst(rst), .we_i(we_i), .data_i(data_i),
      .data0_o(d0_5), .data1_o(d1_5), .data2_o(d2_5), .done_o(done_5));
   fifo_double_line_buffer #(.DATA_WIDTH(8), .LINE_WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .we_i(we_i), .data_i(data_i),
      .data0_o(d0_2), .data1_o(d1_2), .data2_o(d2_2), .done_o(done_2));
   fifo_double_line_buffer #(.DATA_WIDTH(8), .LINE_WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .we_i(we_i), .data_i(data_i),
      .data0_o(d0_8), .data1_o(d1_8), .data2_o(d2_8), .done_o(done_8));

   function automatic col_t act5();
      return '{done: done_5, d2: d2_5, d1: d1_5, d0: d0_5};
   endfunction
   function automatic col_t act2();
      return '{done: done_2, d2: d2_2, d1: d1_2, d0: d0_2};
   endfunction
   function automatic col_t act8();
      return '{done: done_8, d2: d2_8, d1: d1_8, d0: d0_8};
   endfunction

   // Column expected after the most recent write, for a given line width.
   function automatic col_t model(int lw);
      col_t c;
      int   k;
      k      = hist.size() - 1;
      c.d0   = 8'(hist[k]);
      c.d1   = (k >= lw)     ? 8'(hist[k - lw])     : 8'd0;
      c.d2   = (k >= 2 * lw) ? 8'(hist[k - 2 * lw]) : 8'd0;
      c.done = (k >= 2 * lw);
      return c;
   endfunction

   task automatic check(input string name, input col_t act, input col_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got done=%0d col=(%0d,%0d,%0d) want done=%0d col=(%0d,%0d,%0d)",
                  name, act.done, act.d0, act.d1, act.d2, exp.done, exp.d0, exp.d1, exp.d2);
      end
   endtask

   // Drive one cycle of stimulus, push the model's prediction, wait one
   // clock and compare every instance against the popped entry.
   task automatic drive(input logic we, input logic [7:0] data);
      sb_t e;
      we_i   = we;
      data_i = data;
      if (we) begin
         hist.push_back(int'(data));
         last5 = model(5);
         last2 = model(2);
         last8 = model(8);
      end else begin
         last5.done = 1'b0;
         last2.done = 1'b0;
         last8.done = 1'b0;
      end
      sb_q.push_back('{c5: last5, c2: last2, c8: last8});
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard: queue empty at compare");
      end else begin
         e = sb_q.pop_front();
         check($sformatf("sb_lw5 px=%0d we=%0d", data, we), act5(), e.c5);
         check($sformatf("sb_lw2 px=%0d we=%0d", data, we), act2(), e.c2);
         check($sformatf("sb_lw8 px=%0d we=%0d", data, we), act8(), e.c8);
      end
   endtask

   // Asynchronous reset pulse between clock edges; outputs must clear
   // before any further clock edge arrives.
   task automatic reset_pulse(input string name);
      we_i = 1'b0;
      rst  = 1'b1;
      #2;
      check({name, "_lw5"}, act5(), '0);
      check({name, "_lw2"}, act2(), '0);
      check({name, "_lw8"}, act8(), '0);
      rst = 1'b0;
      hist.delete();
      last5 = '0;
      last2 = '0;
      last8 = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Stall sequence for LINE_WIDTH=5: pixels 0..7, three idle cycles,
      // then pixels 8..12. Expected columns written out by hand.
      tab[0]  = '{1'b1, 8'd0,  '{1'b0, 8'd0, 8'd0, 8'd0}};
      tab[1]  = '{1'b1, 8'd1,  '{1'b0, 8'd0, 8'd0, 8'd1}};
      tab[2]  = '{1'b1, 8'd2,  '{1'b0, 8'd0, 8'd0, 8'd2}};
      tab[3]  = '{1'b1, 8'd3,  '{1'b0, 8'd0, 8'd0, 8'd3}};
      tab[4]  = '{1'b1, 8'd4,  '{1'b0, 8'd0, 8'd0, 8'd4}};
      tab[5]  = '{1'b1, 8'd5,  '{1'b0, 8'd0, 8'd0, 8'd5}};
      tab[6]  = '{1'b1, 8'd6,  '{1'b0, 8'd0, 8'd1, 8'd6}};
      tab[7]  = '{1'b1, 8'd7,  '{1'b0, 8'd0, 8'd2, 8'd7}};
      tab[8]  = '{1'b0, 8'd99, '{1'b0, 8'd0, 8'd2, 8'd7}};
      tab[9]  = '{1'b0, 8'd98, '{1'b0, 8'd0, 8'd2, 8'd7}};
      tab[10] = '{1'b0, 8'd97, '{1'b0, 8'd0, 8'd2, 8'd7}};
      tab[11] = '{1'b1, 8'd8,  '{1'b0, 8'd0, 8'd3, 8'd8}};
      tab[12] = '{1'b1, 8'd9,  '{1'b0, 8'd0, 8'd4, 8'd9}};
      tab[13] = '{1'b1, 8'd10, '{1'b1, 8'd0, 8'd5, 8'd10}};
      tab[14] = '{1'b1, 8'd11, '{1'b1, 8'd1, 8'd6, 8'd11}};
      tab[15] = '{1'b1, 8'd12, '{1'b1, 8'd2, 8'd7, 8'd12}};
      // tab[5] expects d1=0 at k=5? No: k=5 reads pixel 0, which is 0.

      last5 = '0;
      last2 = '0;
      last8 = '0;

      // Reset held over two edges, then released with we_i low.
      repeat (2) @(posedge clk);
      #1;
      check("reset_lw5", act5(), '0);
      check("reset_lw2", act2(), '0);
      check("reset_lw8", act8(), '0);
      rst = 1'b0;
      drive(1'b0, 8'hAA);
      check("idle_after_reset", act5(), '0);

      // Table-driven stall sequence.
      for (int i = 0; i < 16; i++) begin
         drive(tab[i].we, tab[i].data);
         check($sformatf("stall_tab[%0d]", i), act5(), tab[i].exp);
      end

      // Fill and stream 0..29 across many index wraps.
      reset_pulse("reset_async");
      for (int k = 0; k < 30; k++) begin
         drive(1'b1, 8'(k));
         if (k == 9)  check("first_done_lw5_low",  act5(), '{1'b0, 8'd0, 8'd4, 8'd9});
         if (k == 10) check("first_done_lw5",      act5(), '{1'b1, 8'd0, 8'd5, 8'd10});
         if (k == 14) check("column_14_lw5",       act5(), '{1'b1, 8'd4, 8'd9, 8'd14});
         if (k == 4)  check("first_done_lw2",      act2(), '{1'b1, 8'd0, 8'd2, 8'd4});
         if (k == 16) check("first_done_lw8",      act8(), '{1'b1, 8'd0, 8'd8, 8'd16});
      end
      check("column_29_lw5", act5(), '{1'b1, 8'd19, 8'd24, 8'd29});
      drive(1'b0, 8'd0);
      check("done_drops_on_idle", act5(), '{1'b0, 8'd19, 8'd24, 8'd29});

      // Reset mid-stream: old pixels must never reappear.
      reset_pulse("reset_pre_mid");
      for (int k = 0; k < 13; k++) drive(1'b1, 8'(k));
      reset_pulse("reset_mid");
      for (int k = 0; k < 15; k++) begin
         drive(1'b1, 8'(100 + k));
         if (k == 0)  check("restart_col",     act5(), '{1'b0, 8'd0, 8'd0, 8'd100});
         if (k == 9)  check("restart_no_done", act5(), '{1'b0, 8'd0, 8'd104, 8'd109});
         if (k == 10) check("restart_done",    act5(), '{1'b1, 8'd100, 8'd105, 8'd110});
      end

      if (sb_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
